// File: rtl/miner_pkg.sv
// Shared widths and state encoding for the multi-core nonce scheduler.
package miner_pkg;

  localparam int HEADER_W = 608;
  localparam int TARGET_W = 256;
  localparam int HASH_W   = 256;
  localparam int NONCE_W  = 32;
  localparam int TX_W     = 288;
  localparam int RX_W     = HEADER_W + TARGET_W;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_DISPATCH = 2'd1,
    S_DRAIN    = 2'd2
  } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// One-hot round-robin picker: first asserted request at or after the pointer,
// wrapping modulo N.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [N-1:0]     grant_o,
  output logic             valid_o
);

  logic [PTR_W:0]   sum;
  logic [PTR_W-1:0] idx;

  always_comb begin
    grant_o = '0;
    valid_o = 1'b0;
    sum     = '0;
    idx     = '0;
    for (int off = 0; off < N; off++) begin
      sum = {1'b0, ptr_i} + (PTR_W+1)'(off);
      if (sum >= (PTR_W+1)'(N)) sum = sum - (PTR_W+1)'(N);
      idx = sum[PTR_W-1:0];
      if (!valid_o && req_i[idx]) begin
        grant_o[idx] = 1'b1;
        valid_o      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/nonce_scheduler.sv
// Hands out consecutive nonces round-robin to NUM_CORES hash cores, collects
// their results and reports the first hash at or below the target.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// S_IDLE     | no work; stray results are acked and discarded
// S_DISPATCH | issuing nonces to free cores and collecting results
// S_DRAIN    | range issued; waiting for the remaining results
module nonce_scheduler
  import miner_pkg::*;
#(
  parameter int          NUM_CORES  = 4,
  parameter logic [31:0] NONCE_LAST = 32'hFFFF_FFFF
) (
  input  logic                        clk,
  input  logic                        n_rst,
  input  logic                        data_ready,
  input  logic [RX_W-1:0]             rx_data,
  output logic [HEADER_W-1:0]         core_header,
  output logic [NONCE_W-1:0]          core_nonce,
  output logic [NUM_CORES-1:0]        core_start,
  input  logic [NUM_CORES-1:0]        core_busy,
  input  logic [NUM_CORES-1:0]        core_done,
  input  logic [NUM_CORES*HASH_W-1:0] core_hash,
  output logic [NUM_CORES-1:0]        core_ack,
  output logic                        core_abort,
  output logic                        send_data,
  output logic [TX_W-1:0]             tx_data,
  output logic                        exhausted,
  output logic                        busy
);

  localparam int PTR_W = $clog2(NUM_CORES);

  sched_state_t         state_q, state_d;
  logic [HEADER_W-1:0]  header_q, header_d;
  logic [TARGET_W-1:0]  target_q, target_d;
  logic [NONCE_W:0]     next_nonce_q, next_nonce_d;
  logic [NUM_CORES-1:0] outstanding_q, outstanding_d;
  logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [NONCE_W-1:0]   nonce_tbl_q [NUM_CORES];

  logic [NUM_CORES-1:0] start_q, start_d;
  logic [NUM_CORES-1:0] ack_q, ack_d;
  logic [NONCE_W-1:0]   nonce_q, nonce_d;
  logic [TX_W-1:0]      tx_q, tx_d;
  logic                 abort_q, abort_d;
  logic                 send_q, send_d;
  logic                 exh_q, exh_d;
  logic                 busy_q;

  // A core acked last cycle may still show its old done level; ignore it once.
  logic [NUM_CORES-1:0] done_eff, sel_oh;
  logic                 sel_vld, sel_out, hit;
  logic [HASH_W-1:0]    sel_hash;
  logic [NONCE_W-1:0]   sel_nonce;

  always_comb begin
    done_eff  = core_done & ~ack_q;
    sel_oh    = '0;
    sel_vld   = 1'b0;
    sel_hash  = '0;
    sel_nonce = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (done_eff[i] && !sel_vld) begin
        sel_oh[i] = 1'b1;
        sel_vld   = 1'b1;
        sel_hash  = core_hash[i*HASH_W +: HASH_W];
        sel_nonce = nonce_tbl_q[i];
      end
    end
    sel_out = |(sel_oh & outstanding_q);
    hit     = sel_out && (sel_hash <= target_q);
  end

  logic [NUM_CORES-1:0] req, grant;
  logic                 grant_vld;
  logic [PTR_W-1:0]     grant_idx;

  assign req = ~outstanding_q & ~core_busy;

  rr_arbiter #(
    .N     (NUM_CORES),
    .PTR_W (PTR_W)
  ) u_rr_arbiter (
    .req_i   (req),
    .ptr_i   (rr_ptr_q),
    .grant_o (grant),
    .valid_o (grant_vld)
  );

  always_comb begin
    grant_idx = '0;
    for (int j = 0; j < NUM_CORES; j++) begin
      if (grant[j]) grant_idx = PTR_W'(j);
    end
  end

  always_comb begin
    state_d       = state_q;
    header_d      = header_q;
    target_d      = target_q;
    next_nonce_d  = next_nonce_q;
    outstanding_d = outstanding_q;
    rr_ptr_d      = rr_ptr_q;
    start_d       = '0;
    nonce_d       = nonce_q;
    ack_d         = '0;
    abort_d       = 1'b0;
    send_d        = 1'b0;
    tx_d          = tx_q;
    exh_d         = 1'b0;

    if (sel_vld) begin
      ack_d         = sel_oh;
      outstanding_d = outstanding_q & ~sel_oh;
    end

    case (state_q)
      S_IDLE: begin
        if (data_ready) begin
          header_d      = rx_data[RX_W-1:TARGET_W];
          target_d      = rx_data[TARGET_W-1:0];
          next_nonce_d  = '0;
          outstanding_d = '0;
          state_d       = S_DISPATCH;
        end
      end
      S_DISPATCH, S_DRAIN: begin
        if (data_ready) begin
          // New work pre-empts everything, including a hit found this cycle.
          abort_d       = 1'b1;
          outstanding_d = '0;
          header_d      = rx_data[RX_W-1:TARGET_W];
          target_d      = rx_data[TARGET_W-1:0];
          next_nonce_d  = '0;
          state_d       = S_DISPATCH;
        end else if (hit) begin
          send_d        = 1'b1;
          tx_d          = {sel_nonce, sel_hash};
          abort_d       = 1'b1;
          outstanding_d = '0;
          state_d       = S_IDLE;
        end else begin
          if (state_q == S_DISPATCH && grant_vld && !next_nonce_q[NONCE_W]) begin
            start_d       = grant;
            nonce_d       = next_nonce_q[NONCE_W-1:0];
            outstanding_d = outstanding_d | grant;
            rr_ptr_d      = (grant_idx == PTR_W'(NUM_CORES-1)) ? '0 : grant_idx + 1'b1;
            next_nonce_d  = next_nonce_q + 1'b1;
            if (next_nonce_q[NONCE_W-1:0] == NONCE_LAST) state_d = S_DRAIN;
          end
          if (state_q == S_DRAIN && sel_out && outstanding_d == '0) begin
            exh_d   = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q       <= S_IDLE;
      header_q      <= '0;
      target_q      <= '0;
      next_nonce_q  <= '0;
      outstanding_q <= '0;
      rr_ptr_q      <= '0;
      start_q       <= '0;
      ack_q         <= '0;
      nonce_q       <= '0;
      tx_q          <= '0;
      abort_q       <= 1'b0;
      send_q        <= 1'b0;
      exh_q         <= 1'b0;
      busy_q        <= 1'b0;
      for (int k = 0; k < NUM_CORES; k++) nonce_tbl_q[k] <= '0;
    end else begin
      state_q       <= state_d;
      header_q      <= header_d;
      target_q      <= target_d;
      next_nonce_q  <= next_nonce_d;
      outstanding_q <= outstanding_d;
      rr_ptr_q      <= rr_ptr_d;
      start_q       <= start_d;
      ack_q         <= ack_d;
      nonce_q       <= nonce_d;
      tx_q          <= tx_d;
      abort_q       <= abort_d;
      send_q        <= send_d;
      exh_q         <= exh_d;
      busy_q        <= (state_d != S_IDLE);
      for (int k = 0; k < NUM_CORES; k++) begin
        if (start_d[k]) nonce_tbl_q[k] <= nonce_d;
      end
    end
  end

  assign core_header = header_q;
  assign core_nonce  = nonce_q;
  assign core_start  = start_q;
  assign core_ack    = ack_q;
  assign core_abort  = abort_q;
  assign send_data   = send_q;
  assign tx_data     = tx_q;
  assign exhausted   = exh_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_nonce_scheduler.sv
// Directed bench for nonce_scheduler with a small behavioural hash-core model.
module tb_nonce_scheduler;
  import miner_pkg::*;

  localparam int          NC = 4;
  localparam logic [31:0] NL = 32'd7;
  localparam logic [TARGET_W-1:0] TGT    = {64'h00000000_FFFF0000, 192'h0};
  localparam logic [HEADER_W-1:0] HDR_A  = {19{32'hA5A5_0001}};
  localparam logic [HEADER_W-1:0] HDR_B  = {19{32'h5A5A_0002}};
  localparam logic [TX_W-1:0]     TX_HIT = {32'd2, 256'd1};

  logic                 clk = 1'b0;
  logic                 n_rst = 1'b0;
  logic                 data_ready = 1'b0;
  logic [RX_W-1:0]      rx_data = '0;
  logic [HEADER_W-1:0]  core_header;
  logic [NONCE_W-1:0]   core_nonce;
  logic [NC-1:0]        core_start;
  logic [NC-1:0]        core_busy;
  logic [NC-1:0]        core_done;
  logic [NC*HASH_W-1:0] core_hash;
  logic [NC-1:0]        core_ack;
  logic                 core_abort;
  logic                 send_data;
  logic [TX_W-1:0]      tx_data;
  logic                 exhausted;
  logic                 busy;

  nonce_scheduler #(.NUM_CORES(NC), .NONCE_LAST(NL)) dut (
    .clk(clk), .n_rst(n_rst), .data_ready(data_ready), .rx_data(rx_data),
    .core_header(core_header), .core_nonce(core_nonce), .core_start(core_start),
    .core_busy(core_busy), .core_done(core_done), .core_hash(core_hash),
    .core_ack(core_ack), .core_abort(core_abort), .send_data(send_data),
    .tx_data(tx_data), .exhausted(exhausted), .busy(busy)
  );

  always #5 clk = ~clk;

  // Core model, updated on the falling edge from the DUT's registered outputs.
  logic [NC-1:0]     busy_m = '0, done_m = '0;
  logic [HASH_W-1:0] hash_m [NC];
  logic [31:0]       nonce_m [NC];
  int                cnt_m [NC];
  int                start_cnt = 0, ack_cnt = 0, send_cnt = 0, exh_cnt = 0;
  int                st_core [256];
  logic [31:0]       st_nonce [256];
  int                st_cyc [256];
  int                cyc = 0;

  logic [NC-1:0]     hold_busy = '0, inj_done = '0;
  logic [HASH_W-1:0] inj_hash = '0;
  int                lat [NC];
  logic [31:0]       hit_nonce = 32'hFFFF_FFFF;

  int checks = 0, errors = 0;

  assign core_busy = busy_m | hold_busy;
  assign core_done = done_m | inj_done;

  always_comb begin
    core_hash = '0;
    for (int i = 0; i < NC; i++)
      core_hash[i*HASH_W +: HASH_W] = inj_done[i] ? inj_hash : hash_m[i];
  end

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (!n_rst) begin
      busy_m = '0;
      done_m = '0;
      for (int i = 0; i < NC; i++) begin
        cnt_m[i] = 0; hash_m[i] = '0; nonce_m[i] = '0;
      end
    end else begin
      if (send_data) send_cnt = send_cnt + 1;
      if (exhausted) exh_cnt = exh_cnt + 1;
      for (int i = 0; i < NC; i++) begin
        if (core_ack[i]) begin ack_cnt = ack_cnt + 1; done_m[i] = 1'b0; end
        if (core_abort) begin busy_m[i] = 1'b0; done_m[i] = 1'b0; cnt_m[i] = 0; end
        if (core_start[i]) begin
          nonce_m[i] = core_nonce; cnt_m[i] = lat[i]; busy_m[i] = 1'b1; done_m[i] = 1'b0;
          if (start_cnt < 256) begin
            st_core[start_cnt] = i; st_nonce[start_cnt] = core_nonce; st_cyc[start_cnt] = cyc;
          end
          start_cnt = start_cnt + 1;
        end else if (busy_m[i]) begin
          if (cnt_m[i] <= 1) begin
            busy_m[i] = 1'b0; done_m[i] = 1'b1;
            hash_m[i] = (nonce_m[i] == hit_nonce) ? 256'd1 : {HASH_W{1'b1}};
          end else cnt_m[i] = cnt_m[i] - 1;
        end
      end
    end
  end

  task automatic step();
    @(negedge clk); #1;
  endtask

  task automatic drive_work(input logic [HEADER_W-1:0] h, input logic [TARGET_W-1:0] t);
    rx_data = {h, t}; data_ready = 1'b1;
    step();
    data_ready = 1'b0;
  endtask

  task automatic do_reset();
    n_rst = 1'b0; inj_done = '0; hold_busy = '0;
    step(); step();
    n_rst = 1'b1;
    step();
  endtask

  task automatic set_lat(input int l0, input int l1, input int l2, input int l3);
    lat[0] = l0; lat[1] = l1; lat[2] = l2; lat[3] = l3;
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    step(); step();
    checks++; if (core_start !== 4'b0 || core_ack !== 4'b0) begin errors++;
      $display("FAIL reset_start_ack: start=%b ack=%b want 0", core_start, core_ack); end
    checks++; if (core_abort !== 1'b0 || send_data !== 1'b0 || exhausted !== 1'b0) begin errors++;
      $display("FAIL reset_pulses: abort=%b send=%b exh=%b want 0", core_abort, send_data, exhausted); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (tx_data !== '0 || core_header !== '0 || core_nonce !== '0) begin errors++;
      $display("FAIL reset_data: tx/header/nonce not zero, nonce=%h", core_nonce); end
    n_rst = 1'b1;
    step();
  endtask

  task automatic test_basic_hit();
    int b_send;
    set_lat(4, 4, 4, 4); hit_nonce = 32'd2; b_send = send_cnt;
    drive_work(HDR_A, TGT);
    checks++; if (core_start !== 4'b0) begin errors++;
      $display("FAIL hit_start_early: got %b want 0000", core_start); end
    step();
    checks++; if (core_start !== 4'b0001 || core_nonce !== 32'd0) begin errors++;
      $display("FAIL hit_first_start: start=%b nonce=%0d want 0001/0", core_start, core_nonce); end
    for (int k = 0; k < 40 && send_data !== 1'b1; k++) step();
    checks++; if (send_data !== 1'b1) begin errors++;
      $display("FAIL hit_timeout: send_data=%b want 1", send_data); end
    checks++; if (tx_data !== TX_HIT) begin errors++;
      $display("FAIL hit_tx: got nonce=%h hash_lsw=%h want nonce=2 hash=1", tx_data[287:256], tx_data[31:0]); end
    checks++; if (core_abort !== 1'b1 || core_ack !== 4'b0100 || busy !== 1'b0) begin errors++;
      $display("FAIL hit_side: abort=%b ack=%b busy=%b want 1/0100/0", core_abort, core_ack, busy); end
    checks++; if (core_header !== HDR_A) begin errors++;
      $display("FAIL hit_header: got %h want %h", core_header[31:0], HDR_A[31:0]); end
    repeat (5) step();
    checks++; if (send_cnt - b_send !== 1) begin errors++;
      $display("FAIL hit_count: got %0d sends want 1", send_cnt - b_send); end
  endtask

  task automatic test_reset_midrun();
    int b_st, b_send;
    logic acked;
    checks++; if (tx_data !== TX_HIT) begin errors++;
      $display("FAIL tx_hold: got %h want %h", tx_data[287:256], TX_HIT[287:256]); end
    set_lat(3, 3, 3, 3); hit_nonce = 32'hFFFF_FFFF; b_st = start_cnt;
    drive_work(HDR_B, TGT);
    for (int k = 0; k < 100 && start_cnt - b_st < 8; k++) step();
    step();
    checks++; if (busy !== 1'b1 || start_cnt - b_st !== 8) begin errors++;
      $display("FAIL drain_busy: busy=%b starts=%0d want 1/8", busy, start_cnt - b_st); end
    n_rst = 1'b0; #1;
    checks++; if (busy !== 1'b0 || tx_data !== '0 || core_header !== '0 || core_ack !== 4'b0) begin errors++;
      $display("FAIL async_reset: busy=%b ack=%b tx_msw=%h want 0", busy, core_ack, tx_data[287:256]); end
    step();
    checks++; if (core_abort !== 1'b0 || core_start !== 4'b0) begin errors++;
      $display("FAIL reset_no_abort: abort=%b start=%b want 0", core_abort, core_start); end
    n_rst = 1'b1; step();
    b_st = start_cnt; b_send = send_cnt; acked = 1'b0;
    inj_hash = 256'd1; inj_done[1] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      if (core_ack[1] === 1'b1) begin acked = 1'b1; inj_done[1] = 1'b0; end
    end
    inj_done = '0;
    checks++; if (acked !== 1'b1) begin errors++; $display("FAIL idle_ack: acked=%b want 1", acked); end
    checks++; if (start_cnt != b_st || send_cnt != b_send || busy !== 1'b0) begin errors++;
      $display("FAIL idle_ignore: starts=%0d sends=%0d busy=%b want 0/0/0",
               start_cnt - b_st, send_cnt - b_send, busy); end
  endtask

  task automatic test_round_robin();
    int b;
    do_reset();
    set_lat(50, 3, 50, 50); hit_nonce = 32'hFFFF_FFFF; b = start_cnt;
    drive_work(HDR_A, TGT);
    for (int k = 0; k < 40 && start_cnt - b < 5; k++) step();
    checks++; if (start_cnt - b < 5) begin errors++;
      $display("FAIL rr_timeout: got %0d starts want 5", start_cnt - b); end
    else begin
      for (int k = 0; k < 4; k++) begin
        checks++; if (st_core[b+k] != k || st_nonce[b+k] !== 32'(k) || st_cyc[b+k] != st_cyc[b] + k) begin
          errors++;
          $display("FAIL rr_start%0d: core=%0d nonce=%0d dcyc=%0d want core=%0d nonce=%0d dcyc=%0d",
                   k, st_core[b+k], st_nonce[b+k], st_cyc[b+k] - st_cyc[b], k, k, k);
        end
      end
      checks++; if (st_core[b+4] != 1 || st_nonce[b+4] !== 32'd4) begin errors++;
        $display("FAIL rr_refill: core=%0d nonce=%0d want core=1 nonce=4", st_core[b+4], st_nonce[b+4]); end
    end
  endtask

  task automatic test_exhaustion();
    int b_st, b_ack, b_send, b_exh;
    logic seq_ok;
    do_reset();
    set_lat(3, 3, 3, 3); hit_nonce = 32'hFFFF_FFFF;
    b_st = start_cnt; b_ack = ack_cnt; b_send = send_cnt; b_exh = exh_cnt;
    drive_work(HDR_A, TGT);
    for (int k = 0; k < 200 && exhausted !== 1'b1; k++) step();
    checks++; if (exhausted !== 1'b1) begin errors++;
      $display("FAIL exh_timeout: exhausted=%b want 1", exhausted); end
    checks++; if (ack_cnt - b_ack != 8 || start_cnt - b_st != 8) begin errors++;
      $display("FAIL exh_counts: acks=%0d starts=%0d want 8/8", ack_cnt - b_ack, start_cnt - b_st); end
    seq_ok = 1'b1;
    for (int k = 0; k < 8; k++) if (st_nonce[b_st+k] !== 32'(k)) seq_ok = 1'b0;
    checks++; if (seq_ok !== 1'b1) begin errors++;
      $display("FAIL exh_nonce_seq: nonces not 0..7 in order, got %b want 1", seq_ok); end
    repeat (10) step();
    checks++; if (exh_cnt - b_exh != 1 || send_cnt != b_send || busy !== 1'b0 || start_cnt - b_st != 8) begin
      errors++;
      $display("FAIL exh_after: exh=%0d sends=%0d busy=%b starts=%0d want 1/0/0/8",
               exh_cnt - b_exh, send_cnt - b_send, busy, start_cnt - b_st);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    set_lat(6, 60, 4, 60); hit_nonce = 32'd2;
    drive_work(HDR_A, TGT);
    for (int k = 0; k < 40 && core_ack === 4'b0; k++) step();
    checks++; if (core_ack !== 4'b0001 || send_data !== 1'b0) begin errors++;
      $display("FAIL sim_first: ack=%b send=%b want 0001/0", core_ack, send_data); end
    step();
    checks++; if (core_ack !== 4'b0100 || send_data !== 1'b1 || core_abort !== 1'b1) begin errors++;
      $display("FAIL sim_second: ack=%b send=%b abort=%b want 0100/1/1", core_ack, send_data, core_abort); end
    checks++; if (tx_data !== TX_HIT) begin errors++;
      $display("FAIL sim_tx: nonce=%h want 2", tx_data[287:256]); end
  endtask

  task automatic test_preempt();
    int b, b_send;
    logic seq_ok, seen;
    do_reset();
    hold_busy = 4'b1000; set_lat(3, 3, 3, 60); hit_nonce = 32'hFFFF_FFFF; b = start_cnt;
    drive_work(HDR_A, TGT);
    for (int k = 0; k < 60 && start_cnt - b < 6; k++) step();
    seq_ok = (start_cnt - b == 6);
    for (int k = 0; k < 6; k++) if (st_nonce[b+k] !== 32'(k)) seq_ok = 1'b0;
    checks++; if (seq_ok !== 1'b1) begin errors++;
      $display("FAIL pre_issue: starts=%0d want nonces 0..5", start_cnt - b); end
    b_send = send_cnt;
    drive_work(HDR_B, TGT);
    checks++; if (core_abort !== 1'b1 || core_start !== 4'b0) begin errors++;
      $display("FAIL pre_abort: abort=%b start=%b want 1/0000", core_abort, core_start); end
    for (int k = 0; k < 10 && core_start === 4'b0; k++) step();
    checks++; if (core_start === 4'b0 || core_nonce !== 32'd0 || core_header !== HDR_B) begin errors++;
      $display("FAIL pre_restart: start=%b nonce=%0d hdr=%h want nonce 0 hdr %h",
               core_start, core_nonce, core_header[31:0], HDR_B[31:0]); end
    inj_hash = 256'd1; inj_done[3] = 1'b1; seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      step();
      if (core_ack[3] === 1'b1) begin seen = 1'b1; inj_done[3] = 1'b0; end
    end
    inj_done = '0;
    checks++; if (seen !== 1'b1 || send_data !== 1'b0) begin errors++;
      $display("FAIL stale_ack: seen=%b send=%b want 1/0", seen, send_data); end
    repeat (5) step();
    checks++; if (send_cnt != b_send) begin errors++;
      $display("FAIL stale_send: got %0d sends want 0", send_cnt - b_send); end
  endtask

  initial begin
    set_lat(4, 4, 4, 4);
    test_reset();
    test_basic_hit();
    test_reset_midrun();
    test_round_robin();
    test_exhaustion();
    test_simultaneous();
    test_preempt();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule
